// File: rtl/alu4_pkg.sv
// Shared types and constants for the ALU4 host link: opcodes, FSM states,
// response flag positions and overflow helpers.
package alu4_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_ROL   = 4'h8,
    OP_ROR   = 4'h9,
    OP_INC   = 4'hA,
    OP_DEC   = 4'hB,
    OP_NEG   = 4'hC,
    OP_CMP   = 4'hD,
    OP_PASSA = 4'hE,
    OP_PASSB = 4'hF
  } alu4_op_t;

  typedef enum logic [1:0] {
    ST_WAIT_OP = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_EXEC    = 2'd2,
    ST_RESP    = 2'd3
  } alu4_state_t;

  localparam int unsigned FLAG_C = 7;
  localparam int unsigned FLAG_Z = 6;
  localparam int unsigned FLAG_N = 5;
  localparam int unsigned FLAG_V = 4;

  localparam logic [BYTE_W-1:0] ALU4_ERR_RSP = 8'hEE;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic [NIB_W-1:0] x, input logic [NIB_W-1:0] y,
                                   input logic [NIB_W-1:0] s);
    return (x[NIB_W-1] == y[NIB_W-1]) && (s[NIB_W-1] != x[NIB_W-1]);
  endfunction

  // Signed overflow of x - y: operands differ in sign and the result flips from x.
  function automatic logic sub_ovf(input logic [NIB_W-1:0] x, input logic [NIB_W-1:0] y,
                                   input logic [NIB_W-1:0] d);
    return (x[NIB_W-1] != y[NIB_W-1]) && (d[NIB_W-1] != x[NIB_W-1]);
  endfunction

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU: (op, a, b) -> (r, c, z, n, v). Arithmetic is done
// 5 bits wide so bit 4 carries the carry-out or the borrow.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] r,
  output logic       c,
  output logic       z,
  output logic       n,
  output logic       v
);

  alu4_op_t   op_e;
  logic [4:0] sum_ab, dif_ab, inc_a, dec_a, neg_a;
  logic [3:0] flag_src;
  logic       cmp_sel;

  assign op_e   = alu4_op_t'(op);
  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign dif_ab = {1'b0, a} - {1'b0, b};
  assign inc_a  = {1'b0, a} + 5'd1;
  assign dec_a  = {1'b0, a} - 5'd1;
  assign neg_a  = 5'd0 - {1'b0, a};

  always_comb begin
    r       = 4'h0;
    c       = 1'b0;
    v       = 1'b0;
    cmp_sel = 1'b0;
    case (op_e)
      OP_ADD:   begin r = sum_ab[3:0]; c = sum_ab[4]; v = add_ovf(a, b, sum_ab[3:0]); end
      OP_SUB:   begin r = dif_ab[3:0]; c = dif_ab[4]; v = sub_ovf(a, b, dif_ab[3:0]); end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_SHL:   begin r = {a[2:0], 1'b0}; c = a[3]; end
      OP_SHR:   begin r = {1'b0, a[3:1]}; c = a[0]; end
      OP_ROL:   begin r = {a[2:0], a[3]}; c = a[3]; end
      OP_ROR:   begin r = {a[0], a[3:1]}; c = a[0]; end
      OP_INC:   begin r = inc_a[3:0]; c = inc_a[4]; v = add_ovf(a, 4'd1, inc_a[3:0]); end
      OP_DEC:   begin r = dec_a[3:0]; c = dec_a[4]; v = sub_ovf(a, 4'd1, dec_a[3:0]); end
      OP_NEG:   begin r = neg_a[3:0]; c = neg_a[4]; v = sub_ovf(4'd0, a, neg_a[3:0]); end
      OP_CMP:   begin r = a; c = dif_ab[4]; v = sub_ovf(a, b, dif_ab[3:0]); cmp_sel = 1'b1; end
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = 4'h0;
    endcase
    // CMP reports Z/N of the difference while passing A through.
    flag_src = cmp_sel ? dif_ab[3:0] : r;
    z        = (flag_src == 4'h0);
    n        = flag_src[3];
  end

endmodule

// File: rtl/alu4_host_link.sv
// Host-side frame responder: collects {op,A} and {P,B} bytes, runs them through
// alu4_core and returns {C,Z,N,V,R}. Define ALU4_PARITY_EN to check frame parity.
module alu4_host_link
  import alu4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] err_cnt
);

  localparam int unsigned    CNT_W     = 8;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic           TMO_EN    = (TIMEOUT != 0);

  alu4_state_t      state, state_nxt;
  logic [3:0]       op_q, a_q, b_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             in_xfer, ld_a, ld_b, tmo_err, par_fail, err_inc;
  logic [3:0]       alu_r;
  logic             alu_c, alu_z, alu_n, alu_v;
  logic [7:0]       rsp_c;

  alu4_core u_core (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .r  (alu_r),
    .c  (alu_c),
    .z  (alu_z),
    .n  (alu_n),
    .v  (alu_v)
  );

  assign in_xfer = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT_OP;
    else     state <= state_nxt;
  end

  // A byte in the timeout cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    tmo_err   = 1'b0;
    case (state)
      ST_WAIT_OP: if (in_xfer) begin ld_a = 1'b1; state_nxt = ST_WAIT_B; end
      ST_WAIT_B: begin
        if (in_xfer) begin
          ld_b      = 1'b1;
          state_nxt = ST_EXEC;
        end else if (TMO_EN && (tmo_cnt == TMO_LIMIT)) begin
          tmo_err   = 1'b1;
          state_nxt = ST_WAIT_OP;
        end
      end
      ST_EXEC:    state_nxt = ST_RESP;
      ST_RESP:    if (out_ready) state_nxt = ST_WAIT_OP;
      default:    state_nxt = ST_WAIT_OP;
    endcase
  end

`ifdef ALU4_PARITY_EN
  logic par_err_q;

  // Whole frame including P must XOR to zero.
  always_ff @(posedge clk) begin
    if (rst)       par_err_q <= 1'b0;
    else if (ld_b) par_err_q <= ^{op_q, a_q, in_data};
  end

  assign par_fail = (state == ST_EXEC) && par_err_q;
`else
  assign par_fail = 1'b0;
`endif

  assign err_inc = tmo_err | par_fail;

  always_comb begin
    rsp_c         = 8'h00;
    rsp_c[3:0]    = alu_r;
    rsp_c[FLAG_C] = alu_c;
    rsp_c[FLAG_Z] = alu_z;
    rsp_c[FLAG_N] = alu_n;
    rsp_c[FLAG_V] = alu_v;
    if (par_fail) rsp_c = ALU4_ERR_RSP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 4'h0;
      a_q       <= 4'h0;
      b_q       <= 4'h0;
      out_data  <= 8'h00;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err_cnt   <= 8'h00;
      tmo_cnt   <= '0;
    end else begin
      if (ld_a) {op_q, a_q} <= in_data;
      if (ld_b) b_q <= in_data[3:0];
      if (state == ST_EXEC) out_data <= rsp_c;
      in_ready  <= (state_nxt == ST_WAIT_OP) || (state_nxt == ST_WAIT_B);
      out_valid <= (state_nxt == ST_RESP);
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      // Idle cycles counted only while a frame is half received.
      if ((state != ST_WAIT_B) || in_valid) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu4_host_link.sv
// Bench for alu4_host_link (TIMEOUT=4): directed, random and protocol scenarios
// checked against an integer-arithmetic model of the ALU4 response byte.
module tb_alu4_host_link;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] err_cnt;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int exp_err = 0;
  int unsigned cyc = 0;

  alu4_host_link #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference response from signed/unsigned integer ranges.
  function automatic logic [7:0] ref_rsp(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, sa, sb, s, t, r, zn;
    bit c, v;
    ai = int'(a); bi = int'(b);
    sa = (ai > 7) ? ai - 16 : ai;
    sb = (bi > 7) ? bi - 16 : bi;
    c = 0; v = 0; t = 0; s = 0; r = 0;
    case (op)
      4'h0: begin s = ai + bi; r = s & 15; c = (s > 15); t = sa + sb; v = (t > 7) || (t < -8); end
      4'h1: begin s = ai - bi; r = s & 15; c = (ai < bi); t = sa - sb; v = (t > 7) || (t < -8); end
      4'h2: r = ai & bi;
      4'h3: r = ai | bi;
      4'h4: r = ai ^ bi;
      4'h5: r = 15 - ai;
      4'h6: begin r = (ai * 2) & 15; c = (ai >= 8); end
      4'h7: begin r = ai / 2; c = (ai % 2 == 1); end
      4'h8: begin r = ((ai * 2) & 15) + ai / 8; c = (ai >= 8); end
      4'h9: begin r = ai / 2 + (ai % 2) * 8; c = (ai % 2 == 1); end
      4'hA: begin r = (ai + 1) & 15; c = (ai == 15); v = (sa + 1 > 7); end
      4'hB: begin r = (ai + 15) & 15; c = (ai == 0); v = (sa - 1 < -8); end
      4'hC: begin r = (16 - ai) & 15; c = (ai != 0); v = (-sa > 7); end
      4'hD: begin r = ai; c = (ai < bi); t = sa - sb; v = (t > 7) || (t < -8); end
      4'hE: r = ai;
      default: r = bi;
    endcase
    zn = (op == 4'hD) ? ((ai - bi) & 15) : r;
    return {c, (zn == 0), (zn >= 8), v, 4'(r)};
  endfunction

  function automatic logic [7:0] mk_b1(input logic [7:0] b0, input logic [3:0] b, input logic [2:0] junk);
    logic [6:0] low;
    low = {junk, b};
    return {^{b0, low}, low};
  endfunction

  // Present one byte from a negedge; returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 0;
    in_data = b;
    in_valid = 1'b1;
    for (int n = 0; n < 16 && !in_ready; n++) @(negedge clk);
    if (in_ready) begin ok = 1; @(posedge clk); end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic get_rsp(output logic [7:0] d, output bit ok);
    ok = 0;
    d = 8'h00;
    out_ready = 1'b1;
    for (int n = 0; n < 16 && !out_valid; n++) @(negedge clk);
    if (out_valid) begin d = out_data; ok = 1; @(posedge clk); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'h00) $display("FAIL reset_err_cnt: got %h want 00", err_cnt); else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [7:0] b0s [3] = '{8'h09, 8'h13, 8'hD5};
    logic [7:0] b1s [3] = '{8'h88, 8'h85, 8'h85};
    logic [7:0] exps[3] = '{8'h91, 8'hAE, 8'h45};
    logic [7:0] d;
    bit ok0, ok1, ok2;
    for (int i = 0; i < 3; i++) begin
      send_byte(b0s[i], ok0);
      send_byte(b1s[i], ok1);
      chk_cnt++; if (!ok0 || !ok1 || out_valid !== 1'b0)
        $display("FAIL directed_exec_%0d: accepted %b%b out_valid %b want 11 0", i, ok0, ok1, out_valid); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b1 || out_data !== exps[i])
        $display("FAIL directed_rsp_%0d: got valid %b data %h want 1 %h", i, out_valid, out_data, exps[i]); else pass_cnt++;
      get_rsp(d, ok2);
      chk_cnt++; if (!ok2 || in_ready !== 1'b1)
        $display("FAIL directed_accept_%0d: accepted %b in_ready %b want 1 1", i, ok2, in_ready); else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [3:0] op, a, b;
    logic [7:0] b0, b1, d, exp;
    bit ok0, ok1, ok2;
    for (int i = 0; i < 64; i++) begin
      op = 4'(i % 16);
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      b0 = {op, a};
      b1 = mk_b1(b0, b, 3'($urandom_range(0, 7)));
      exp = ref_rsp(op, a, b);
      send_byte(b0, ok0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(b1, ok1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      get_rsp(d, ok2);
      chk_cnt++; if (!(ok0 && ok1 && ok2) || d !== exp)
        $display("FAIL random_op%h_a%h_b%h: got %h (hs %b%b%b) want %h", op, a, b, d, ok0, ok1, ok2, exp); else pass_cnt++;
    end
    chk_cnt++; if (err_cnt !== 8'(exp_err)) $display("FAIL random_err_cnt: got %0d want %0d", err_cnt, exp_err); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] op, a, b;
    logic [7:0] b0, exp;
    int unsigned t_prev, t_now;
    bit ok0, ok1;
    t_prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      b0 = {op, a};
      exp = ref_rsp(op, a, b);
      send_byte(b0, ok0);
      send_byte(mk_b1(b0, b, 3'd0), ok1);
      t_now = cyc;
      @(negedge clk);
      chk_cnt++; if (!ok0 || !ok1 || out_valid !== 1'b1 || out_data !== exp)
        $display("FAIL b2b_rsp_%0d: got valid %b data %h want 1 %h", i, out_valid, out_data, exp); else pass_cnt++;
      if (i > 0) begin
        chk_cnt++; if (t_now - t_prev !== 4)
          $display("FAIL b2b_period_%0d: got %0d cycles want 4", i, t_now - t_prev); else pass_cnt++;
      end
      t_prev = t_now;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [7:0] b0;
    int bad;
    bit ok0, ok1;
    b0 = 8'hA7;
    send_byte(b0, ok0);
    send_byte(mk_b1(b0, 4'($urandom_range(0, 15)), 3'd5), ok1);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h38) bad++;
      @(negedge clk);
    end
    chk_cnt++; if (!ok0 || !ok1 || bad != 0)
      $display("FAIL backpressure_hold: got %0d unstable cycles data %h want 0 and 38", bad, out_data); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL backpressure_still_valid: got %b want 1", out_valid); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL backpressure_release: got in_ready %b out_valid %b want 1 0", in_ready, out_valid); else pass_cnt++;
  endtask

  task automatic test_timeout;
    logic [7:0] d;
    int bad;
    bit ok0, ok1, ok2;
    send_byte(8'h5A, ok0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (err_cnt !== 8'(exp_err) || out_valid !== 1'b0) bad++;
      if (i < 4) @(negedge clk);
    end
    @(negedge clk);
    exp_err++;
    chk_cnt++; if (!ok0 || bad != 0) $display("FAIL timeout_early: got %0d early events want 0", bad); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'(exp_err) || out_valid !== 1'b0)
      $display("FAIL timeout_err_cnt: got %0d valid %b want %0d 0", err_cnt, out_valid, exp_err); else pass_cnt++;
    send_byte(8'h09, ok0);
    send_byte(8'h88, ok1);
    get_rsp(d, ok2);
    chk_cnt++; if (!(ok0 && ok1 && ok2) || d !== 8'h91)
      $display("FAIL timeout_next_frame: got %h want 91", d); else pass_cnt++;
    // Second byte lands exactly in the timeout cycle and must win.
    send_byte(8'h13, ok0);
    repeat (4) @(negedge clk);
    send_byte(8'h85, ok1);
    get_rsp(d, ok2);
    chk_cnt++; if (!(ok0 && ok1 && ok2) || d !== 8'hAE || err_cnt !== 8'(exp_err))
      $display("FAIL timeout_edge_byte: got %h err %0d want AE err %0d", d, err_cnt, exp_err); else pass_cnt++;
  endtask

  task automatic test_parity;
    logic [7:0] d, exp;
    bit ok0, ok1, ok2;
`ifdef ALU4_PARITY_EN
    exp = 8'hEE;
    exp_err++;
`else
    exp = 8'h91;
`endif
    send_byte(8'h09, ok0);
    send_byte(8'h08, ok1);
    get_rsp(d, ok2);
    chk_cnt++; if (!(ok0 && ok1 && ok2) || d !== exp) $display("FAIL parity_rsp: got %h want %h", d, exp); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'(exp_err)) $display("FAIL parity_err_cnt: got %0d want %0d", err_cnt, exp_err); else pass_cnt++;
  endtask

  task automatic test_err_saturate;
    bit ok0;
    int lost;
    lost = 0;
    for (int i = 0; i < 257; i++) begin
      send_byte(8'($urandom), ok0);
      if (!ok0) lost++;
      repeat (5) @(negedge clk);
    end
    exp_err = (exp_err + 257 > 255) ? 255 : exp_err + 257;
    chk_cnt++; if (lost != 0 || err_cnt !== 8'(exp_err))
      $display("FAIL err_saturate: got %0d (lost %0d) want %0d", err_cnt, lost, exp_err); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    bit ok0, ok1, ok2;
    send_byte(8'h09, ok0);
    send_byte(8'h88, ok1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || err_cnt !== 8'h00)
      $display("FAIL reset_midframe: got valid %b ready %b data %h err %h want 0 1 00 00",
               out_valid, in_ready, out_data, err_cnt); else pass_cnt++;
    send_byte(8'hD5, ok0);
    send_byte(8'h85, ok1);
    get_rsp(d, ok2);
    chk_cnt++; if (!(ok0 && ok1 && ok2) || d !== 8'h45)
      $display("FAIL reset_then_frame: got %h want 45", d); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_parity;
    test_err_saturate;
    test_reset_midframe;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
